core_decode: RTL and testbench

- RV32I instruction decode stage, placed between the fetch stage and the execute stage.
- Accepts the instruction word and PC from fetch using a valid/ready handshake.
- Decodes register indices, the sign-extended immediate, the format class and legality.
- Holds the result in a single pipeline register with a valid/ready handshake toward execute.
- Supports a flush that kills in-flight work when execute redirects the PC.

---
 rtl/core_decode.sv | 158 +++++++++++++++
 tb/tb_core_decode.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/core_decode.sv
// RV32I decode stage: a single pipeline register between fetch and execute
// that carries register indices, the immediate, the format class and legality.
module core_decode #(
   parameter logic [31:0] NOP_IR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        d_valid,
   input  logic [31:0] d_ir,
   input  logic [31:0] d_pc,
   output logic        d_ready,
   input  logic        flush,
   output logic        e_valid,
   input  logic        e_ready,
   output logic [31:0] e_pc,
   output logic [31:0] e_ir,
   output logic [4:0]  e_rs1,
   output logic [4:0]  e_rs2,
   output logic [4:0]  e_rd,
   output logic [31:0] e_imm,
   output logic [2:0]  e_fmt,
   output logic        e_we,
   output logic        e_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_MISC   = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [6:0] F7_ALT = 7'b0100000;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [2:0]  dec_fmt;
   logic        dec_illegal;
   logic [31:0] dec_imm;
   logic        dec_we;
   logic        take;

   assign opcode = d_ir[6:0];
   assign funct3 = d_ir[14:12];
   assign funct7 = d_ir[31:25];

   assign d_ready = !e_valid || e_ready;
   assign take    = d_ready && d_valid && !flush;

   always_comb begin
      dec_fmt     = FMT_I;
      dec_illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_fmt     = FMT_R;
            dec_illegal = !((funct7 == 7'd0) ||
                            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            if (funct3 == 3'b001)
               dec_illegal = (funct7 != 7'd0);
            else if (funct3 == 3'b101)
               dec_illegal = (funct7 != 7'd0) && (funct7 != F7_ALT);
         end
         OPC_LOAD:
            dec_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         OPC_JALR:
            dec_illegal = (funct3 != 3'b000);
         OPC_MISC, OPC_SYSTEM:
            dec_fmt = FMT_I;
         OPC_STORE: begin
            dec_fmt     = FMT_S;
            dec_illegal = (funct3 > 3'd2);
         end
         OPC_BRANCH: begin
            dec_fmt     = FMT_B;
            dec_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_LUI, OPC_AUIPC:
            dec_fmt = FMT_U;
         OPC_JAL:
            dec_fmt = FMT_J;
         default:
            dec_illegal = 1'b1;
      endcase
      // Compressed/reserved quadrants never reach the opcode list, but keep it explicit.
      if (d_ir[1:0] != 2'b11)
         dec_illegal = 1'b1;
   end

   always_comb begin
      dec_imm = 32'd0;
      case (dec_fmt)
         FMT_I:   dec_imm = {{20{d_ir[31]}}, d_ir[31:20]};
         FMT_S:   dec_imm = {{20{d_ir[31]}}, d_ir[31:25], d_ir[11:7]};
         FMT_B:   dec_imm = {{19{d_ir[31]}}, d_ir[31], d_ir[7], d_ir[30:25], d_ir[11:8], 1'b0};
         FMT_U:   dec_imm = {d_ir[31:12], 12'd0};
         FMT_J:   dec_imm = {{11{d_ir[31]}}, d_ir[31], d_ir[19:12], d_ir[20], d_ir[30:21], 1'b0};
         default: dec_imm = 32'd0;
      endcase
   end

   assign dec_we = !dec_illegal && (d_ir[11:7] != 5'd0) &&
                   (dec_fmt == FMT_R || dec_fmt == FMT_I || dec_fmt == FMT_U || dec_fmt == FMT_J);

   // Whenever the register goes invalid it is refilled with a NOP payload,
   // so a flushed or absent instruction never shows up on e_*.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_valid   <= 1'b0;
         e_pc      <= 32'd0;
         e_ir      <= NOP_IR;
         e_rs1     <= 5'd0;
         e_rs2     <= 5'd0;
         e_rd      <= 5'd0;
         e_imm     <= 32'd0;
         e_fmt     <= FMT_I;
         e_we      <= 1'b0;
         e_illegal <= 1'b0;
      end else if (take) begin
         e_valid   <= 1'b1;
         e_pc      <= d_pc;
         e_ir      <= d_ir;
         e_rs1     <= d_ir[19:15];
         e_rs2     <= d_ir[24:20];
         e_rd      <= d_ir[11:7];
         e_imm     <= dec_imm;
         e_fmt     <= dec_fmt;
         e_we      <= dec_we;
         e_illegal <= dec_illegal;
      end else if (flush || d_ready) begin
         e_valid   <= 1'b0;
         e_pc      <= 32'd0;
         e_ir      <= NOP_IR;
         e_rs1     <= 5'd0;
         e_rs2     <= 5'd0;
         e_rd      <= 5'd0;
         e_imm     <= 32'd0;
         e_fmt     <= FMT_I;
         e_we      <= 1'b0;
         e_illegal <= 1'b0;
      end
   end

endmodule

// File: tb/tb_core_decode.sv
// Directed bench for core_decode: each task drives one scenario and checks
// the decode register against hand-computed values.
module tb_core_decode;

   logic        clk = 1'b0;
   logic        rst;
   logic        d_valid;
   logic [31:0] d_ir;
   logic [31:0] d_pc;
   logic        d_ready;
   logic        flush;
   logic        e_valid;
   logic        e_ready;
   logic [31:0] e_pc;
   logic [31:0] e_ir;
   logic [4:0]  e_rs1;
   logic [4:0]  e_rs2;
   logic [4:0]  e_rd;
   logic [31:0] e_imm;
   logic [2:0]  e_fmt;
   logic        e_we;
   logic        e_illegal;

   int n_cmp = 0;
   int n_err = 0;

   core_decode dut (
      .clk(clk), .rst(rst),
      .d_valid(d_valid), .d_ir(d_ir), .d_pc(d_pc), .d_ready(d_ready),
      .flush(flush),
      .e_valid(e_valid), .e_ready(e_ready), .e_pc(e_pc), .e_ir(e_ir),
      .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_imm(e_imm),
      .e_fmt(e_fmt), .e_we(e_we), .e_illegal(e_illegal)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; d_valid = 1'b0; d_ir = 32'd0; d_pc = 32'd0; flush = 1'b0; e_ready = 1'b1;
      #12;
      n_cmp++; if (e_valid !== 1'b0) begin n_err++; $display("FAIL reset_e_valid got %h want 0", e_valid); end
      n_cmp++; if (e_ir !== 32'h00000013) begin n_err++; $display("FAIL reset_e_ir got %h want 00000013", e_ir); end
      n_cmp++; if (e_fmt !== 3'd1) begin n_err++; $display("FAIL reset_e_fmt got %0d want 1", e_fmt); end
      n_cmp++; if ({e_pc, e_imm, e_rs1, e_rs2, e_rd, e_we, e_illegal} !== 83'd0) begin n_err++; $display("FAIL reset_payload got pc=%h imm=%h not all zero", e_pc, e_imm); end
      n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL reset_d_ready got %b want 1", d_ready); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      $display("reset: e_valid=%b e_ir=%h", e_valid, e_ir);
   endtask

   task automatic test_addi();
      d_valid = 1'b1; d_ir = 32'h00500093; d_pc = 32'h100; e_ready = 1'b1;
      tick();
      d_valid = 1'b0;
      $display("addi: pc=%h ir=%h rd=%0d imm=%h fmt=%0d we=%b", e_pc, e_ir, e_rd, e_imm, e_fmt, e_we);
      n_cmp++; if (e_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b want 1", e_valid); end
      n_cmp++; if (e_pc !== 32'h100) begin n_err++; $display("FAIL addi_pc got %h want 00000100", e_pc); end
      n_cmp++; if (e_rd !== 5'd1 || e_rs1 !== 5'd0) begin n_err++; $display("FAIL addi_regs got rd=%0d rs1=%0d want rd=1 rs1=0", e_rd, e_rs1); end
      n_cmp++; if (e_imm !== 32'd5) begin n_err++; $display("FAIL addi_imm got %h want 00000005", e_imm); end
      n_cmp++; if (e_fmt !== 3'd1 || e_we !== 1'b1 || e_illegal !== 1'b0) begin n_err++; $display("FAIL addi_ctl got fmt=%0d we=%b ill=%b want 1/1/0", e_fmt, e_we, e_illegal); end
      tick();
      n_cmp++; if (e_valid !== 1'b0) begin n_err++; $display("FAIL addi_drain got %b want 0", e_valid); end
   endtask

   task automatic test_back_to_back();
      e_ready = 1'b1; d_valid = 1'b1;
      d_ir = 32'h0020A223; d_pc = 32'h200;
      tick();
      $display("b2b sw: pc=%h fmt=%0d imm=%h we=%b", e_pc, e_fmt, e_imm, e_we);
      n_cmp++; if (e_valid !== 1'b1 || e_fmt !== 3'd2 || e_imm !== 32'd4 || e_we !== 1'b0) begin n_err++; $display("FAIL b2b_sw got v=%b fmt=%0d imm=%h we=%b want 1/2/00000004/0", e_valid, e_fmt, e_imm, e_we); end
      n_cmp++; if (e_rs1 !== 5'd1 || e_rs2 !== 5'd2) begin n_err++; $display("FAIL b2b_sw_regs got rs1=%0d rs2=%0d want 1/2", e_rs1, e_rs2); end
      d_ir = 32'hFE000EE3; d_pc = 32'h204;
      tick();
      $display("b2b beq: pc=%h fmt=%0d imm=%h", e_pc, e_fmt, e_imm);
      n_cmp++; if (e_valid !== 1'b1 || e_pc !== 32'h204) begin n_err++; $display("FAIL b2b_nobubble got v=%b pc=%h want 1/00000204", e_valid, e_pc); end
      n_cmp++; if (e_fmt !== 3'd3 || e_imm !== 32'hFFFFFFFC || e_we !== 1'b0) begin n_err++; $display("FAIL b2b_beq got fmt=%0d imm=%h we=%b want 3/fffffffc/0", e_fmt, e_imm, e_we); end
      d_ir = 32'h008000EF; d_pc = 32'h208;
      tick();
      $display("b2b jal: pc=%h fmt=%0d imm=%h we=%b", e_pc, e_fmt, e_imm, e_we);
      n_cmp++; if (e_fmt !== 3'd5 || e_imm !== 32'd8 || e_we !== 1'b1 || e_rd !== 5'd1) begin n_err++; $display("FAIL b2b_jal got fmt=%0d imm=%h we=%b rd=%0d want 5/00000008/1/1", e_fmt, e_imm, e_we, e_rd); end
      d_valid = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      e_ready = 1'b0; d_valid = 1'b1; d_ir = 32'h00500093; d_pc = 32'h300;
      tick();
      d_ir = 32'h123450B7; d_pc = 32'h304;
      for (int i = 0; i < 3; i++) begin
         #1;
         $display("stall %0d: d_ready=%b e_pc=%h e_ir=%h", i, d_ready, e_pc, e_ir);
         n_cmp++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL stall_d_ready cyc %0d got %b want 0", i, d_ready); end
         n_cmp++; if (e_valid !== 1'b1 || e_ir !== 32'h00500093 || e_pc !== 32'h300 || e_imm !== 32'd5) begin n_err++; $display("FAIL stall_hold cyc %0d got v=%b ir=%h pc=%h imm=%h", i, e_valid, e_ir, e_pc, e_imm); end
         tick();
      end
      e_ready = 1'b1;
      #1;
      n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got %b want 1", d_ready); end
      tick();
      d_valid = 1'b0;
      $display("stall release: pc=%h ir=%h fmt=%0d imm=%h", e_pc, e_ir, e_fmt, e_imm);
      n_cmp++; if (e_valid !== 1'b1 || e_ir !== 32'h123450B7 || e_pc !== 32'h304) begin n_err++; $display("FAIL stall_release got v=%b ir=%h pc=%h want 1/123450b7/00000304", e_valid, e_ir, e_pc); end
      n_cmp++; if (e_fmt !== 3'd4 || e_imm !== 32'h12345000 || e_we !== 1'b1) begin n_err++; $display("FAIL lui_decode got fmt=%0d imm=%h we=%b want 4/12345000/1", e_fmt, e_imm, e_we); end
      tick();
   endtask

   task automatic test_flush();
      e_ready = 1'b1; d_valid = 1'b1; d_ir = 32'h00500093; d_pc = 32'h400;
      tick();
      e_ready = 1'b0; flush = 1'b1; d_ir = 32'h123450B7; d_pc = 32'h404;
      tick();
      flush = 1'b0;
      $display("flush: e_valid=%b e_ir=%h e_pc=%h", e_valid, e_ir, e_pc);
      n_cmp++; if (e_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", e_valid); end
      e_ready = 1'b1; d_valid = 1'b0;
      tick();
      n_cmp++; if (e_valid !== 1'b0 || e_ir === 32'h123450B7) begin n_err++; $display("FAIL flush_killed got v=%b ir=%h want v=0 and not 123450b7", e_valid, e_ir); end
      // Flush also wins over a transfer that would otherwise happen.
      d_valid = 1'b1; flush = 1'b1; d_ir = 32'h00500093;
      tick();
      flush = 1'b0; d_valid = 1'b0;
      n_cmp++; if (e_valid !== 1'b0) begin n_err++; $display("FAIL flush_priority got %b want 0", e_valid); end
   endtask

   task automatic test_illegal();
      logic [31:0] irs  [5] = '{32'hFFFFFFFF, 32'h02000033, 32'h40000033, 32'h000010E7, 32'h4010D093};
      logic        ills [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      e_ready = 1'b1; d_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         d_ir = irs[i]; d_pc = 32'h500 + 32'(i * 4);
         tick();
         $display("legality: ir=%h e_valid=%b e_illegal=%b e_we=%b", e_ir, e_valid, e_illegal, e_we);
         n_cmp++; if (e_valid !== 1'b1 || e_illegal !== ills[i]) begin n_err++; $display("FAIL illegal_%0d ir=%h got v=%b ill=%b want 1/%b", i, irs[i], e_valid, e_illegal, ills[i]); end
         if (ills[i]) begin
            n_cmp++; if (e_we !== 1'b0) begin n_err++; $display("FAIL illegal_we_%0d got %b want 0", i, e_we); end
         end
         if (i == 2) begin
            n_cmp++; if (e_fmt !== 3'd0 || e_imm !== 32'd0) begin n_err++; $display("FAIL sub_decode got fmt=%0d imm=%h want 0/00000000", e_fmt, e_imm); end
         end
         if (i == 4) begin
            n_cmp++; if (e_imm !== 32'h00000401 || e_we !== 1'b1) begin n_err++; $display("FAIL srai_decode got imm=%h we=%b want 00000401/1", e_imm, e_we); end
         end
      end
      d_valid = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      e_ready = 1'b0; d_valid = 1'b1; d_ir = 32'h00500093; d_pc = 32'h600;
      tick();
      n_cmp++; if (e_valid !== 1'b1) begin n_err++; $display("FAIL areset_setup got %b want 1", e_valid); end
      #2 rst = 1'b1;
      #1;
      $display("async reset: e_valid=%b e_ir=%h e_we=%b d_ready=%b", e_valid, e_ir, e_we, d_ready);
      n_cmp++; if (e_valid !== 1'b0 || e_ir !== 32'h00000013 || e_we !== 1'b0 || d_ready !== 1'b1) begin n_err++; $display("FAIL areset got v=%b ir=%h we=%b rdy=%b want 0/00000013/0/1", e_valid, e_ir, e_we, d_ready); end
      #2 rst = 1'b0;
      d_valid = 1'b0; e_ready = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_stall();
      test_flush();
      test_illegal();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
